// File: rtl/sr_latch_bank.sv
// sr_latch_bank: clocked bank of WIDTH set/reset latches with a programmable settle delay.
// A rising edge on enable_i starts a sample; after SETTLE_CYCLES clocks every channel
// updates from s_i/r_i if enable_i is still high (update pulse), otherwise the sample is
// dropped (abort pulse). Simultaneous s=r=1 is resolved by CONFLICT_MODE.
// Optional feature: define SR_LATCH_BANK_STATS_EN to add a saturating conflict counter.
module sr_latch_bank #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 10,
  parameter int unsigned CONFLICT_MODE = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] r_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qb_o,
  output logic             busy_o,
  output logic             update_o,
  output logic             abort_o,
  output logic [WIDTH-1:0] conflict_o
`ifdef SR_LATCH_BANK_STATS_EN
  ,
  output logic [7:0]       conflict_count_o
`endif
);

  localparam bit        ZeroSettle = (SETTLE_CYCLES == 0);
  // Counter preload; unused when the delay is zero.
  localparam logic [7:0] CntLoad   = ZeroSettle ? 8'd0 : 8'(SETTLE_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StSettle} state_e;

  state_e           state_q;
  logic [7:0]       cnt_q;
  logic             en_q;
  logic             busy_q;
  logic             update_q;
  logic             abort_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] conflict_q;
  logic [WIDTH-1:0] hits;
  logic             rise;
  logic             sample;

  // Edge detect, sample-point decode and per-channel next latch value.
  always_comb begin
    rise   = enable_i & ~en_q;
    hits   = s_i & r_i;
    sample = 1'b0;
    unique case (state_q)
      StIdle:   sample = rise & ZeroSettle;
      StSettle: sample = (cnt_q == 8'd0);
      default:  sample = 1'b0;
    endcase
    q_d = q_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({s_i[i], r_i[i]})
        2'b10:   q_d[i] = 1'b1;
        2'b01:   q_d[i] = 1'b0;
        2'b11: begin
          if (CONFLICT_MODE == 1)      q_d[i] = 1'b1;
          else if (CONFLICT_MODE == 2) q_d[i] = 1'b0;
          else                         q_d[i] = q_q[i];
        end
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  // Settle FSM with registered latch state and status pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      update_q   <= 1'b0;
      abort_q    <= 1'b0;
      q_q        <= '0;
      conflict_q <= '0;
    end else begin
      en_q     <= enable_i;
      update_q <= 1'b0;
      abort_q  <= 1'b0;
      if (sample) begin
        if (enable_i) begin
          q_q        <= q_d;
          conflict_q <= hits;
          update_q   <= 1'b1;
        end else begin
          abort_q <= 1'b1;
        end
      end
      unique case (state_q)
        StIdle: begin
          if (rise && !ZeroSettle) begin
            cnt_q   <= CntLoad;
            busy_q  <= 1'b1;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          // Edges on enable_i are ignored here; the delay never restarts.
          if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SR_LATCH_BANK_STATS_EN
  logic [7:0] conflict_count_q;

  // Saturating count of completed samples that saw any s=r=1 channel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_count_q <= 8'd0;
    end else if (sample && enable_i && (|hits) && (conflict_count_q != 8'hFF)) begin
      conflict_count_q <= conflict_count_q + 8'd1;
    end
  end

  assign conflict_count_o = conflict_count_q;
`endif

  assign q_o        = q_q;
  assign qb_o       = ~q_q;
  assign busy_o     = busy_q;
  assign update_o   = update_q;
  assign abort_o    = abort_q;
  assign conflict_o = conflict_q;

endmodule
